// File: rtl/relu_backward_stream.sv
// relu_backward_stream: streaming ReLU gradient gate driven by a captured forward sign/zero mask
module relu_backward_stream #(
  parameter int W = 28,
  parameter int H = 28,
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mask_load,
  input  logic [W*H*DATA_WIDTH-1:0] fwd_map,
  input  logic                      grad_valid,
  output logic                      grad_ready,
  input  logic [DATA_WIDTH-1:0]     grad_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     grad_out,
  output logic                      busy,
  output logic                      frame_done
);
  localparam int N = W * H;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {EMPTY, ACTIVE, DRAIN} state_t;
  state_t state, state_nx;
  logic [N-1:0] mask, mask_cap;
  logic [IW-1:0] idx;
  logic accept, out_hs, last;
  for (genvar i = 0; i < N; i++) begin : g_mask
    assign mask_cap[i] = !fwd_map[DATA_WIDTH*(N-i)-1] && |fwd_map[DATA_WIDTH*(N-i-1) +: DATA_WIDTH];
  end
  assign busy = state != EMPTY;
  assign grad_ready = state == ACTIVE && (!out_valid || out_ready);
  assign accept = grad_valid && grad_ready;
  assign out_hs = out_valid && out_ready;
  assign last = idx == IW'(N - 1);
  always_comb begin
    state_nx = state;
    if (state == EMPTY && mask_load) state_nx = ACTIVE;
    if (state == ACTIVE && accept && last) state_nx = DRAIN;
    if (state == DRAIN && out_hs) state_nx = EMPTY;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      idx        <= '0;
      mask       <= '0;
      out_valid  <= 1'b0;
      grad_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= state == DRAIN && out_hs;
      if (state == EMPTY && mask_load) begin
        mask <= mask_cap;
        idx  <= '0;
      end else if (accept) begin
        idx <= last ? '0 : idx + IW'(1);
      end
      if (state == DRAIN && out_hs) mask <= '0;
      if (accept) begin
        out_valid <= 1'b1;
        grad_out  <= mask[idx] ? grad_in : '0;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_relu_backward_stream.sv
// tb_relu_backward_stream: directed and randomized checks of the ReLU gradient gate against a pixel-level model
module tb_relu_backward_stream;
  localparam int W = 2;
  localparam int H = 2;
  localparam int N = W * H;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst_n, mask_load, grad_valid, out_ready;
  logic grad_ready, out_valid, busy, frame_done;
  logic [N*DW-1:0] fwd_map;
  logic [DW-1:0] grad_in, grad_out;
  logic [15:0] cur_px [4];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  relu_backward_stream #(.W(W), .H(H), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .mask_load(mask_load), .fwd_map(fwd_map),
    .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_in(grad_in),
    .out_valid(out_valid), .out_ready(out_ready), .grad_out(grad_out),
    .busy(busy), .frame_done(frame_done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [N*DW-1:0] pack(input logic [15:0] p [4]);
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[DW*(N-1-i) +: DW] = p[i];
    return r;
  endfunction
  function automatic logic [15:0] gated(input int i, input logic [15:0] g);
    return $signed(cur_px[i]) > 0 ? g : 16'h0000;
  endfunction
  function automatic logic [15:0] pick_px;
    int k;
    k = int'($urandom_range(4));
    return k == 0 ? 16'h0000 : k == 1 ? 16'h8000 : k == 2 ? 16'h0001 : k == 3 ? 16'h7FFF : 16'($urandom);
  endfunction
  task automatic load(input logic [15:0] p [4]);
    fwd_map = pack(p);
    cur_px = p;
    mask_load = 1'b1;
    tick;
    mask_load = 1'b0;
    chk("load_busy", 32'(busy), 32'(1));
  endtask
  task automatic run_frame(input logic [15:0] g [4], input int pv, input int pr, output int cyc);
    int sent, got;
    logic acc, hs;
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < N && cyc < 100) begin
      grad_valid = sent < N && int'($urandom_range(99)) < pv;
      grad_in = grad_valid ? g[sent % N] : 16'($urandom);
      out_ready = int'($urandom_range(99)) < pr;
      #1;
      chk("out_valid", 32'(out_valid), 32'(sent != got));
      chk("grad_ready", 32'(grad_ready), 32'(sent < N && (sent == got || out_ready)));
      hs = out_valid && out_ready;
      acc = grad_valid && grad_ready;
      if (hs) begin
        chk("grad_out", 32'(grad_out), 32'(gated(got, g[got])));
        got++;
      end
      if (acc) sent++;
      tick;
      cyc++;
      chk("frame_done", 32'(frame_done), 32'(got == N));
      chk("busy", 32'(busy), 32'(got != N));
    end
    chk("frame_complete", 32'(got), 32'(N));
    grad_valid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] m1 [4], neg [4], m3 [4], m4 [4], rm [4], g [4];
    int cyc;
    m1 = '{16'h0005, 16'hFFFB, 16'h0000, 16'h7FFF};
    neg = '{16'h8000, 16'hFFFF, 16'hFFFB, 16'h8001};
    m3 = '{16'h7FFF, 16'h0000, 16'h0001, 16'h8000};
    m4 = '{16'hFFFF, 16'h0002, 16'h8001, 16'h0003};
    rst_n = 1'b0; mask_load = 1'b0; grad_valid = 1'b0; out_ready = 1'b0;
    grad_in = '0; fwd_map = '0;
    tick;
    tick;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_grad_out", 32'(grad_out), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));
    chk("rst_grad_ready", 32'(grad_ready), 32'(0));
    rst_n = 1'b1;
    grad_valid = 1'b1; grad_in = 16'h1111; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("idle_grad_ready", 32'(grad_ready), 32'(0));
      tick;
      chk("idle_out_valid", 32'(out_valid), 32'(0));
      chk("idle_grad_out", 32'(grad_out), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));
    end
    grad_valid = 1'b0;
    load(m1);
    run_frame('{16'h0100, 16'h0200, 16'h0300, 16'h0400}, 100, 100, cyc);
    chk("basic_cycles", 32'(cyc), 32'(5));
    tick;
    chk("basic_done_pulse", 32'(frame_done), 32'(0));
    load(m1);
    grad_valid = 1'b1; out_ready = 1'b1; grad_in = 16'h0100;
    tick;
    chk("bp_out0", 32'(grad_out), 32'(16'h0100));
    grad_in = 16'h0200;
    tick;
    chk("bp_out1", 32'(grad_out), 32'(16'h0000));
    chk("bp_out1_valid", 32'(out_valid), 32'(1));
    out_ready = 1'b0; grad_in = 16'h0300;
    mask_load = 1'b1; fwd_map = pack(neg);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_grad_ready", 32'(grad_ready), 32'(0));
      tick;
      mask_load = 1'b0;
      chk("bp_hold_data", 32'(grad_out), 32'(16'h0000));
      chk("bp_hold_valid", 32'(out_valid), 32'(1));
      chk("bp_busy", 32'(busy), 32'(1));
    end
    out_ready = 1'b1;
    tick;
    chk("bp_out2", 32'(grad_out), 32'(16'h0000));
    chk("bp_out2_valid", 32'(out_valid), 32'(1));
    grad_in = 16'h0400;
    tick;
    chk("bp_out3_reload_ignored", 32'(grad_out), 32'(16'h0400));
    chk("bp_out3_valid", 32'(out_valid), 32'(1));
    grad_valid = 1'b0;
    tick;
    chk("bp_drained", 32'(out_valid), 32'(0));
    chk("bp_frame_done", 32'(frame_done), 32'(1));
    chk("bp_busy_fall", 32'(busy), 32'(0));
    tick;
    load(m1);
    grad_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      grad_in = 16'(16'h0100 * (k + 1));
      tick;
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_frame_done", 32'(frame_done), 32'(0));
    grad_in = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mid_rst_refuse", 32'(grad_ready), 32'(0));
      tick;
      chk("mid_rst_no_out", 32'(out_valid), 32'(0));
    end
    grad_valid = 1'b0;
    load(m3);
    run_frame('{16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0}, 100, 100, cyc);
    chk("fresh_cycles", 32'(cyc), 32'(5));
    load(m4);
    run_frame('{16'h1357, 16'h2468, 16'h369C, 16'h48AC}, 100, 100, cyc);
    chk("b2b_cycles", 32'(cyc), 32'(5));
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < N; i++) begin
        rm[i] = pick_px();
        g[i] = 16'($urandom);
      end
      if (int'($urandom_range(1)) == 1) tick;
      load(rm);
      run_frame(g, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
